// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the MEM stage,
// holding a global pipeline stall until every request of the current pipeline cycle is served.
module unified_mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic             m_en,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata,
  output logic [WIDTH-1:0] if_rdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             stall_pipe
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       i_done;
  logic       d_done;
  logic       d_req;
  logic       i_pend;
  logic       d_pend;

  assign d_req      = mem_read | mem_write;
  assign i_pend     = if_req & ~i_done;
  assign d_pend     = d_req & ~d_done;
  assign stall_pipe = i_pend | d_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      // Pipeline advances this edge: open a fresh pipeline cycle.
      if (!stall_pipe) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Data first: the MEM stage holds the older instruction.
          if (d_pend) begin
            state   <= BUSY_D;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
            m_we    <= mem_write;
            m_en    <= 1'b1;
            cnt     <= LAT_M1;
          end else if (i_pend) begin
            state  <= BUSY_I;
            m_addr <= if_addr;
            m_we   <= 1'b0;
            m_en   <= 1'b1;
            cnt    <= LAT_M1;
          end else begin
            m_en <= 1'b0;
            m_we <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Completion: result is captured even if the request has since dropped.
            if (state == BUSY_I) begin
              if_rdata <= m_rdata;
              i_done   <= 1'b1;
            end else begin
              if (!m_we) d_rdata <= m_rdata;
              d_done <= 1'b1;
            end
            m_en  <= 1'b0;
            m_we  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          m_en  <= 1'b0;
          m_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: table-driven cycle vectors at MEM_LAT=2,
// plus hand sequences for reset-mid-access and a MEM_LAT=1 fetch stream.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: MEM_LAT = 2
  logic        reset_a;
  logic        if_req_a, mem_read_a, mem_write_a;
  logic [31:0] if_addr_a, mem_addr_a, mem_wdata_a, m_rdata_a;
  logic        m_en_a, m_we_a, stall_a;
  logic [31:0] m_addr_a, m_wdata_a, if_rdata_a, d_rdata_a;

  unified_mem_arbiter #(.WIDTH(32), .MEM_LAT(2)) dut_a (
    .clk(clk), .reset(reset_a),
    .if_req(if_req_a), .if_addr(if_addr_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .m_en(m_en_a), .m_we(m_we_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a),
    .m_rdata(m_rdata_a), .if_rdata(if_rdata_a), .d_rdata(d_rdata_a),
    .stall_pipe(stall_a)
  );

  // Instance B: MEM_LAT = 1
  logic        reset_b;
  logic        if_req_b, mem_read_b, mem_write_b;
  logic [31:0] if_addr_b, mem_addr_b, mem_wdata_b, m_rdata_b;
  logic        m_en_b, m_we_b, stall_b;
  logic [31:0] m_addr_b, m_wdata_b, if_rdata_b, d_rdata_b;

  unified_mem_arbiter #(.WIDTH(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .reset(reset_b),
    .if_req(if_req_b), .if_addr(if_addr_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b),
    .m_rdata(m_rdata_b), .if_rdata(if_rdata_b), .d_rdata(d_rdata_b),
    .stall_pipe(stall_b)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] m_rdata;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic [31:0] e_ifr;
    logic [31:0] e_dr;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic ifr, input logic [31:0] ia, input logic rd,
                         input logic wr, input logic [31:0] ma, input logic [31:0] wd,
                         input logic [31:0] rdat);
    if_req_a    = ifr;
    if_addr_a   = ia;
    mem_read_a  = rd;
    mem_write_a = wr;
    mem_addr_a  = ma;
    mem_wdata_a = wd;
    m_rdata_a   = rdat;
  endtask

  initial begin
    //                  ifq  if_addr        rd    wr    mem_addr       wdata          m_rdata        en    we    m_addr         m_wdata        stall if_rdata       d_rdata
    // Store, no fetch
    tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h80,        32'h12345678,  32'hCAFEF00D,  1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h80,        32'h12345678,  32'hCAFEF00D,  1'b1, 1'b1, 32'h80,        32'h12345678,  1'b1, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h80,        32'h12345678,  32'hCAFEF00D,  1'b1, 1'b1, 32'h80,        32'h12345678,  1'b1, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h80,        32'h12345678,  32'hCAFEF00D,  1'b0, 1'b0, 32'h80,        32'h12345678,  1'b0, 32'h0,         32'h0};
    // Fetch only at 0x40; data appears only in the final busy cycle
    tbl[4]  = '{1'b1, 32'h40,        1'b0, 1'b0, 32'h0,         32'h0,         32'h11111111,  1'b0, 1'b0, 32'h80,        32'h12345678,  1'b1, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 32'h40,        1'b0, 1'b0, 32'h0,         32'h0,         32'h11111111,  1'b1, 1'b0, 32'h40,        32'h12345678,  1'b1, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, 32'h40,        1'b0, 1'b0, 32'h0,         32'h0,         32'h2002000A,  1'b1, 1'b0, 32'h40,        32'h12345678,  1'b1, 32'h0,         32'h0};
    tbl[7]  = '{1'b1, 32'h40,        1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h40,        32'h12345678,  1'b0, 32'h2002000A,  32'h0};
    // Load 0x100 and fetch 0x44 together: data first, then fetch
    tbl[8]  = '{1'b1, 32'h44,        1'b1, 1'b0, 32'h100,       32'h0,         32'h0,         1'b0, 1'b0, 32'h40,        32'h12345678,  1'b1, 32'h2002000A,  32'h0};
    tbl[9]  = '{1'b1, 32'h44,        1'b1, 1'b0, 32'h100,       32'h0,         32'h0,         1'b1, 1'b0, 32'h100,       32'h0,         1'b1, 32'h2002000A,  32'h0};
    tbl[10] = '{1'b1, 32'h44,        1'b1, 1'b0, 32'h100,       32'h0,         32'hDEADBEEF,  1'b1, 1'b0, 32'h100,       32'h0,         1'b1, 32'h2002000A,  32'h0};
    tbl[11] = '{1'b1, 32'h44,        1'b1, 1'b0, 32'h100,       32'h0,         32'h0,         1'b0, 1'b0, 32'h100,       32'h0,         1'b1, 32'h2002000A,  32'hDEADBEEF};
    tbl[12] = '{1'b1, 32'h44,        1'b1, 1'b0, 32'h100,       32'h0,         32'h0,         1'b1, 1'b0, 32'h44,        32'h0,         1'b1, 32'h2002000A,  32'hDEADBEEF};
    tbl[13] = '{1'b1, 32'h44,        1'b1, 1'b0, 32'h100,       32'h0,         32'h00000013,  1'b1, 1'b0, 32'h44,        32'h0,         1'b1, 32'h2002000A,  32'hDEADBEEF};
    tbl[14] = '{1'b1, 32'h44,        1'b1, 1'b0, 32'h100,       32'h0,         32'h0,         1'b0, 1'b0, 32'h44,        32'h0,         1'b0, 32'h00000013,  32'hDEADBEEF};
    // No requests at all
    tbl[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h44,        32'h0,         1'b0, 32'h00000013,  32'hDEADBEEF};

    reset_a = 1'b1;
    reset_b = 1'b1;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    if_req_b = 1'b0; if_addr_b = 32'h0; mem_read_b = 1'b0; mem_write_b = 1'b0;
    mem_addr_b = 32'h0; mem_wdata_b = 32'h0; m_rdata_b = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_en",     {31'b0, m_en_a},  32'h0);
    chk("rst_m_we",     {31'b0, m_we_a},  32'h0);
    chk("rst_m_addr",   m_addr_a,         32'h0);
    chk("rst_m_wdata",  m_wdata_a,        32'h0);
    chk("rst_if_rdata", if_rdata_a,       32'h0);
    chk("rst_d_rdata",  d_rdata_a,        32'h0);
    reset_a = 1'b0;

    // Table-driven vectors: each entry is one pipeline clock cycle.
    for (int k = 0; k < NV; k++) begin
      drive_a(tbl[k].if_req, tbl[k].if_addr, tbl[k].mem_read, tbl[k].mem_write,
              tbl[k].mem_addr, tbl[k].mem_wdata, tbl[k].m_rdata);
      #1;
      chk($sformatf("v%0d_m_en", k),     {31'b0, m_en_a},  {31'b0, tbl[k].e_en});
      chk($sformatf("v%0d_m_we", k),     {31'b0, m_we_a},  {31'b0, tbl[k].e_we});
      chk($sformatf("v%0d_m_addr", k),   m_addr_a,         tbl[k].e_addr);
      chk($sformatf("v%0d_m_wdata", k),  m_wdata_a,        tbl[k].e_wdata);
      chk($sformatf("v%0d_stall", k),    {31'b0, stall_a}, {31'b0, tbl[k].e_stall});
      chk($sformatf("v%0d_if_rdata", k), if_rdata_a,       tbl[k].e_ifr);
      chk($sformatf("v%0d_d_rdata", k),  d_rdata_a,        tbl[k].e_dr);
      @(negedge clk);
    end

    // Reset during the first cycle of a BUSY_D load, then re-serve it.
    drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0);
    #1 chk("rb_idle_stall", {31'b0, stall_a}, 32'h1);
    @(negedge clk);
    #1 chk("rb_busy_en", {31'b0, m_en_a}, 32'h1);
    chk("rb_busy_addr", m_addr_a, 32'h200);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    #1 chk("rb_after_en",    {31'b0, m_en_a},  32'h0);
    chk("rb_after_d_rdata",  d_rdata_a,        32'h0);
    chk("rb_after_if_rdata", if_rdata_a,       32'h0);
    chk("rb_after_addr",     m_addr_a,         32'h0);
    chk("rb_after_stall",    {31'b0, stall_a}, 32'h1);
    @(negedge clk);
    #1 chk("rb_reserve_en", {31'b0, m_en_a}, 32'h1);
    chk("rb_reserve_addr", m_addr_a, 32'h200);
    @(negedge clk);
    m_rdata_a = 32'h55AA55AA;
    #1 chk("rb_last_en", {31'b0, m_en_a}, 32'h1);
    @(negedge clk);
    m_rdata_a = 32'h0;
    #1 chk("rb_done_en",    {31'b0, m_en_a},  32'h0);
    chk("rb_done_d_rdata",  d_rdata_a,        32'h55AA55AA);
    chk("rb_done_stall",    {31'b0, stall_a}, 32'h0);

    // MEM_LAT=1 fetch stream, PC += 4 on each advance edge.
    reset_b   = 1'b0;
    if_req_b  = 1'b1;
    if_addr_b = 32'h0;
    for (int n = 0; n < 3; n++) begin
      #1 chk($sformatf("l1_%0d_stall0", n), {31'b0, stall_b}, 32'h1);
      chk($sformatf("l1_%0d_en0", n), {31'b0, m_en_b}, 32'h0);
      @(negedge clk);
      m_rdata_b = if_addr_b ^ 32'hA5A50000;
      #1 chk($sformatf("l1_%0d_stall1", n), {31'b0, stall_b}, 32'h1);
      chk($sformatf("l1_%0d_en1", n), {31'b0, m_en_b}, 32'h1);
      chk($sformatf("l1_%0d_addr", n), m_addr_b, 32'(n * 4));
      @(negedge clk);
      m_rdata_b = 32'h0;
      #1 chk($sformatf("l1_%0d_stall2", n), {31'b0, stall_b}, 32'h0);
      chk($sformatf("l1_%0d_en2", n), {31'b0, m_en_b}, 32'h0);
      chk($sformatf("l1_%0d_if_rdata", n), if_rdata_b, 32'(n * 4) ^ 32'hA5A50000);
      @(negedge clk);
      if_addr_b = if_addr_b + 32'h4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
